axi_lite_regfile: RTL

AXI4-Lite responder that terminates host PIO transactions into a bank of 32-bit control/status registers. It sits on the slave side of the PCIe-to-AXI4-Lite bridge and completes the read/write transactions the host issues through BAR space. It handles write address and write data independently, applies byte strobes, and returns OKAY or SLVERR responses. It exposes the register contents and per-register write pulses to the fabric.

---
 rtl/axi_lite_regfile_if.sv | 38 +++
 rtl/axi_lite_regfile.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regfile_if.sv
// -----------------------------------------------------------------------------
// axi4_lite_if
// AXI4-Lite signal bundle with a 32-bit data path.
//   modport s : responder view (used by axi_lite_regfile)
//   modport m : requester view
// Parameter ADDR_W sets the width of awaddr/araddr.
// -----------------------------------------------------------------------------
interface axi4_lite_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport s (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport m (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_regfile.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile
// AXI4-Lite responder terminating host PIO accesses into NUM_REGS 32-bit
// registers. AW and W are captured independently; a write commits on the edge
// where both are (or become) held. At most one write and one read are
// outstanding; the read and write paths are independent.
//
// Ports:
//   aclk        in   clock, rising edge
//   areset      in   synchronous active-high reset
//   axi         s    axi4_lite_if responder modport
//   regs_o      out  register contents, register k at [32k+31:32k]
//   wr_pulse_o  out  one-cycle pulse per register on commit
//
// Build option: define AXI_LITE_REGS_SLVERR_EN to answer out-of-range
// accesses with SLVERR (2'b10); otherwise they complete OKAY and are ignored
// (reads return zero in both builds).
// -----------------------------------------------------------------------------
module axi_lite_regfile #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                  aclk,
    input  logic                  areset,
    axi4_lite_if.s                axi,
    output logic [NUM_REGS*32-1:0] regs_o,
    output logic [NUM_REGS-1:0]   wr_pulse_o
);
    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
`ifdef AXI_LITE_REGS_SLVERR_EN
    localparam logic [1:0]  RESP_OOR  = 2'b10;
`else
    localparam logic [1:0]  RESP_OOR  = 2'b00;
`endif

    logic              aw_held_q, aw_held_d;
    logic [IDX_W-1:0]  aw_idx_q,  aw_idx_d;
    logic              w_held_q,  w_held_d;
    logic [31:0]       w_data_q,  w_data_d;
    logic [3:0]        w_strb_q,  w_strb_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;
    logic              rvalid_q,  rvalid_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic [31:0]       regs_q [NUM_REGS];

    // Readies are forced low during reset so nothing is accepted while the
    // state is being cleared.
    logic aw_hs, w_hs, ar_hs;
    assign axi.awready = !areset && !aw_held_q && !bvalid_q;
    assign axi.wready  = !areset && !w_held_q  && !bvalid_q;
    assign axi.arready = !areset && !rvalid_q;
    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid  && axi.wready;
    assign ar_hs = axi.arvalid && axi.arready;

    // Commit uses the held copy if present, otherwise the live bus value, so a
    // write completing its last handshake commits on that same edge.
    logic             commit;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic [3:0]       wr_strb;
    logic             wr_in_range;
    logic [SEL_W-1:0] wr_sel;
    assign commit      = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_idx      = aw_held_q ? aw_idx_q : axi.awaddr[ADDR_W-1:2];
    assign wr_data     = w_held_q  ? w_data_q : axi.wdata;
    assign wr_strb     = w_held_q  ? w_strb_q : axi.wstrb;
    assign wr_in_range = 32'(wr_idx) < NUM_REGS;
    assign wr_sel      = wr_idx[SEL_W-1:0];

    logic [IDX_W-1:0] rd_idx;
    logic             rd_in_range;
    logic [SEL_W-1:0] rd_sel;
    assign rd_idx      = axi.araddr[ADDR_W-1:2];
    assign rd_in_range = 32'(rd_idx) < NUM_REGS;
    assign rd_sel      = rd_idx[SEL_W-1:0];

    // Byte-offset bits of the address are intentionally ignored.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{axi.awaddr[1:0], axi.araddr[1:0]};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        wr_pulse_d = '0;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = axi.awaddr[ADDR_W-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = axi.wdata;
            w_strb_d = axi.wstrb;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_in_range ? RESP_OKAY : RESP_OOR;
            if (wr_in_range) begin
                wr_pulse_d[wr_sel] = 1'b1;
            end
        end else if (bvalid_q && axi.bready) begin
            bvalid_d = 1'b0;
        end

        // regs_q is the pre-commit value, so a read racing a write to the same
        // register on one edge returns the old contents.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_in_range ? regs_q[rd_sel] : 32'h0;
            rresp_d  = rd_in_range ? RESP_OKAY : RESP_OOR;
        end else if (rvalid_q && axi.rready) begin
            rvalid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            wr_pulse_q <= '0;
        end else begin
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // NOTE: the register bank is reset explicitly because software relies on
    // RESET_VAL; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else if (commit && wr_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    regs_q[wr_sel][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_regs_o
        assign regs_o[32*k +: 32] = regs_q[k];
    end

    assign axi.bvalid = bvalid_q;
    assign axi.bresp  = bresp_q;
    assign axi.rvalid = rvalid_q;
    assign axi.rdata  = rdata_q;
    assign axi.rresp  = rresp_q;
    assign wr_pulse_o = wr_pulse_q;
endmodule
